// File: rtl/count_sweep_ctrl.sv
// Closed-loop direction sequencer for an 8-bit up/down counter: drives `mode`
// so `count` sweeps as a triangle wave between LO and HI for SWEEPS sweeps.
module count_sweep_ctrl #(
   parameter logic [7:0] LO     = 8'd10,
   parameter logic [7:0] HI     = 8'd50,
   parameter logic [7:0] SWEEPS = 8'd4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic [7:0] count,
   output logic       mode,
   output logic       busy,
   output logic [7:0] sweep_cnt,
   output logic       done
);

   if ((int'(HI) - int'(LO)) < 3) begin : g_bad_limits
      $error("count_sweep_ctrl: HI - LO must be at least 3");
   end

   // Turn one step early: the counter still moves with the old mode on the
   // turning edge, so it lands exactly on HI / LO before reversing.
   localparam logic [7:0] HI_TURN = HI - 8'd1;
   localparam logic [7:0] LO_TURN = LO + 8'd1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RAMP_UP = 2'd1,
      RAMP_DN = 2'd2
   } state_e;

   state_e     state_q;
   logic       mode_q;
   logic       busy_q;
   logic       done_q;
   logic [7:0] sweep_cnt_q;
   logic [7:0] sweep_cnt_d;
   logic       at_peak;
   logic       at_trough;
   logic       last_sweep;

   always_comb begin
      sweep_cnt_d = (sweep_cnt_q == 8'hFF) ? sweep_cnt_q : sweep_cnt_q + 8'd1;
      at_peak     = (count >= HI_TURN);
      at_trough   = (count <= LO_TURN);
      last_sweep  = (SWEEPS != 8'd0) && (sweep_cnt_d == SWEEPS);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sweep_cnt_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start && !stop) begin
                  sweep_cnt_q <= '0;
                  busy_q      <= 1'b1;
                  if (at_peak) begin
                     state_q <= RAMP_DN;
                     mode_q  <= 1'b0;
                  end else begin
                     state_q <= RAMP_UP;
                     mode_q  <= 1'b1;
                  end
               end
            end
            RAMP_UP: begin
               if (stop) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (at_peak) begin
                  state_q <= RAMP_DN;
                  mode_q  <= 1'b0;
               end
            end
            RAMP_DN: begin
               if (stop) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (at_trough) begin
                  sweep_cnt_q <= sweep_cnt_d;
                  if (last_sweep) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     mode_q  <= 1'b0;
                  end else begin
                     state_q <= RAMP_UP;
                     mode_q  <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mode      = mode_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Bench for count_sweep_ctrl: behavioural up/down counters close the loop and a
// scoreboard matches expected peaks, troughs and done pulses against the waveform.
module tb_count_sweep_ctrl;

   localparam logic [7:0] LO = 8'd10;
   localparam logic [7:0] HI = 8'd50;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [7:0] count = 8'd0;
   logic       mode, busy, done;
   logic [7:0] sweep_cnt;

   logic       start_f = 1'b0;
   logic [7:0] count_f = 8'd0;
   logic       mode_f, busy_f, done_f;
   logic [7:0] sweep_cnt_f;

   logic       cnt_en = 1'b0, cnt_ld = 1'b0;
   logic [7:0] cnt_ld_val = 8'd0;
   logic       cnt_en_f = 1'b0, cnt_ld_f = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   count_sweep_ctrl #(.LO(LO), .HI(HI), .SWEEPS(8'd2)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .count(count),
      .mode(mode), .busy(busy), .sweep_cnt(sweep_cnt), .done(done)
   );

   count_sweep_ctrl #(.LO(LO), .HI(HI), .SWEEPS(8'd0)) dut_free (
      .clk(clk), .rst(rst), .start(start_f), .stop(stop), .count(count_f),
      .mode(mode_f), .busy(busy_f), .sweep_cnt(sweep_cnt_f), .done(done_f)
   );

   always @(posedge clk) begin
      if (cnt_ld) count <= cnt_ld_val;
      else if (cnt_en) count <= mode ? count + 8'd1 : count - 8'd1;
      if (cnt_ld_f) count_f <= 8'd0;
      else if (cnt_en_f) count_f <= mode_f ? count_f + 8'd1 : count_f - 8'd1;
   end

   // kind 0 = peak (val = count), 1 = trough (val = count, sc = sweep_cnt),
   // 2 = done pulse (val = {busy,mode}, sc = sweep_cnt)
   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] val;
      logic [7:0] sc;
   } ev_t;

   ev_t        exp_q[$];
   logic       mon_en = 1'b0;
   logic [7:0] c1 = 8'd0, c2 = 8'd0;
   int         hist = 0;

   always @(negedge clk) begin : monitor
      ev_t  obs;
      ev_t  ex;
      logic got;
      got = 1'b0;
      obs = '0;
      if (!mon_en) begin
         hist = 0;
      end else begin
         if (done) begin
            obs.kind = 2'd2; obs.val = {6'd0, busy, mode}; obs.sc = sweep_cnt; got = 1'b1;
         end else if (hist >= 2 && c2 < c1 && c1 > count) begin
            obs.kind = 2'd0; obs.val = c1; obs.sc = 8'd0; got = 1'b1;
         end else if (hist >= 2 && c2 > c1 && c1 < count) begin
            obs.kind = 2'd1; obs.val = c1; obs.sc = sweep_cnt; got = 1'b1;
         end
         if (got) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got kind %0d val %0d sc %0d, required no event",
                        obs.kind, obs.val, obs.sc);
            end else begin
               ex = exp_q.pop_front();
               if (obs !== ex) begin
                  errors++;
                  $display("FAIL sb_event: got kind %0d val %0d sc %0d, required kind %0d val %0d sc %0d",
                           obs.kind, obs.val, obs.sc, ex.kind, ex.val, ex.sc);
               end
            end
         end
         c2 = c1;
         c1 = count;
         if (hist < 2) hist++;
      end
   end

   task automatic push_ev(input logic [1:0] k, input logic [7:0] v, input logic [7:0] s);
      ev_t e;
      e.kind = k; e.val = v; e.sc = s;
      exp_q.push_back(e);
   endtask

   // Load the counter, then pulse start; returns just after the start edge.
   task automatic launch(input logic [7:0] v);
      @(negedge clk); #1;
      cnt_en = 1'b0; cnt_ld = 1'b1; cnt_ld_val = v;
      @(negedge clk); #1;
      cnt_ld = 1'b0; start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   task automatic drain_queue(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_timeout: got %0d events outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset;
      #12;
      checks++; if (mode !== 1'b0) begin errors++; $display("FAIL rst_mode: got %b required 0", mode); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
      checks++; if (sweep_cnt !== 8'd0) begin errors++; $display("FAIL rst_sweep_cnt: got %0d required 0", sweep_cnt); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done); end
      @(negedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_sweep_from_zero;
      launch(8'd0);
      checks++; if (mode !== 1'b1) begin errors++; $display("FAIL start0_mode: got %b required 1", mode); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start0_busy: got %b required 1", busy); end
      push_ev(2'd0, HI, 8'd0);
      push_ev(2'd1, LO, 8'd1);
      push_ev(2'd0, HI, 8'd0);
      push_ev(2'd2, 8'd0, 8'd2);
      cnt_en = 1'b1; mon_en = 1'b1;
      drain_queue(400);
      @(negedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width: got %b required 0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL end_busy: got %b required 0", busy); end
      checks++; if (mode !== 1'b0) begin errors++; $display("FAIL end_mode: got %b required 0", mode); end
      checks++; if (sweep_cnt !== 8'd2) begin errors++; $display("FAIL end_sweep_cnt: got %0d required 2", sweep_cnt); end
      cnt_en = 1'b0; mon_en = 1'b0;
   endtask

   task automatic test_start_above;
      launch(8'd200);
      checks++; if (mode !== 1'b0) begin errors++; $display("FAIL above_mode: got %b required 0", mode); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL above_busy: got %b required 1", busy); end
      push_ev(2'd1, LO, 8'd1);
      push_ev(2'd0, HI, 8'd0);
      cnt_en = 1'b1; mon_en = 1'b1;
      drain_queue(400);
      stop = 1'b1;
      @(negedge clk); #1;
      stop = 1'b0; cnt_en = 1'b0; mon_en = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL above_stop_busy: got %b required 0", busy); end
      checks++; if (sweep_cnt !== 8'd1) begin errors++; $display("FAIL above_stop_sc: got %0d required 1", sweep_cnt); end
   endtask

   task automatic test_stop_rising;
      int n;
      launch(8'd0);
      cnt_en = 1'b1;
      n = 0;
      while (count != 8'd30 && n < 100) begin @(negedge clk); #1; n++; end
      checks++; if (count !== 8'd30) begin errors++; $display("FAIL stop_reach30: got %0d required 30", count); end
      stop = 1'b1;
      @(negedge clk); #1;
      stop = 1'b0; cnt_en = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b required 0", busy); end
      checks++; if (mode !== 1'b1) begin errors++; $display("FAIL stop_mode: got %b required 1", mode); end
      checks++; if (sweep_cnt !== 8'd0) begin errors++; $display("FAIL stop_sc: got %0d required 0", sweep_cnt); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_no_done: got %b required 0", done); end
         @(negedge clk); #1;
      end
   endtask

   task automatic test_start_stop_same;
      start = 1'b1; stop = 1'b1;
      @(negedge clk); #1;
      start = 1'b0; stop = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ss_busy: got %b required 0", busy); end
      checks++; if (mode !== 1'b1) begin errors++; $display("FAIL ss_mode: got %b required 1", mode); end
      @(negedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ss_busy2: got %b required 0", busy); end
   endtask

   task automatic test_back_to_back;
      int n;
      launch(8'd0);
      cnt_en = 1'b1;
      n = 0;
      while (sweep_cnt != 8'd1 && n < 200) begin @(negedge clk); #1; n++; end
      checks++; if (sweep_cnt !== 8'd1) begin errors++; $display("FAIL b2b_reach: got %0d required 1", sweep_cnt); end
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      checks++; if (sweep_cnt !== 8'd1) begin errors++; $display("FAIL b2b_sc: got %0d required 1", sweep_cnt); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b required 1", busy); end
      checks++; if (mode !== 1'b1) begin errors++; $display("FAIL b2b_mode: got %b required 1", mode); end
      stop = 1'b1;
      @(negedge clk); #1;
      stop = 1'b0; cnt_en = 1'b0;
   endtask

   task automatic test_free_run;
      int n, dones;
      @(negedge clk); #1;
      cnt_ld_f = 1'b1;
      @(negedge clk); #1;
      cnt_ld_f = 1'b0; start_f = 1'b1;
      @(negedge clk); #1;
      start_f = 1'b0; cnt_en_f = 1'b1;
      n = 0; dones = 0;
      while (sweep_cnt_f != 8'd5 && n < 700) begin
         @(negedge clk); #1;
         if (done_f) dones++;
         n++;
      end
      for (int i = 0; i < 20; i++) begin @(negedge clk); #1; if (done_f) dones++; end
      checks++; if (sweep_cnt_f !== 8'd5) begin errors++; $display("FAIL free_sc: got %0d required 5", sweep_cnt_f); end
      checks++; if (dones !== 0) begin errors++; $display("FAIL free_done: got %0d pulses required 0", dones); end
      checks++; if (busy_f !== 1'b1) begin errors++; $display("FAIL free_busy: got %b required 1", busy_f); end
      stop = 1'b1;
      @(negedge clk); #1;
      stop = 1'b0; cnt_en_f = 1'b0;
      checks++; if (busy_f !== 1'b0) begin errors++; $display("FAIL free_stop: got %b required 0", busy_f); end
   endtask

   task automatic test_reset_mid;
      int n;
      launch(8'd0);
      cnt_en = 1'b1;
      n = 0;
      while (!(sweep_cnt == 8'd1 && mode == 1'b0 && busy == 1'b1) && n < 300) begin
         @(negedge clk); #1; n++;
      end
      checks++; if (sweep_cnt !== 8'd1) begin errors++; $display("FAIL rmid_reach: got %0d required 1", sweep_cnt); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (mode !== 1'b0) begin errors++; $display("FAIL rmid_mode: got %b required 0", mode); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b required 0", busy); end
      checks++; if (sweep_cnt !== 8'd0) begin errors++; $display("FAIL rmid_sc: got %0d required 0", sweep_cnt); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b required 0", done); end
      @(negedge clk); #1;
      rst = 1'b1; cnt_en = 1'b0;
   endtask

   initial begin
      test_reset;
      test_sweep_from_zero;
      test_start_above;
      test_stop_rising;
      test_start_stop_same;
      test_back_to_back;
      test_free_run;
      test_reset_mid;
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
